// File: rtl/servo_pkg.sv
// Shared types, default widths and the command-to-pulse-width decode for the servo PWM array.
package servo_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_FWD  = 2'b01,
    CMD_BACK = 2'b10,
    CMD_STOP = 2'b11
  } cmd_e;

  localparam int unsigned DEF_N_CH      = 2;
  localparam int unsigned DEF_CNT_W     = 12;
  localparam int unsigned DEF_FRAME_LEN = 3072;
  localparam int unsigned DEF_PW_BACK   = 154;
  localparam int unsigned DEF_PW_STOP   = 230;
  localparam int unsigned DEF_PW_FWD    = 307;
  localparam int unsigned DEF_RAMP_STEP = 8;

  // Widest pulse width the decode helper carries; callers narrow to their counter width.
  localparam int unsigned PW_W_MAX = 16;

  function automatic logic [PW_W_MAX-1:0] decode_cmd(
    input cmd_e                cmd,
    input logic [PW_W_MAX-1:0] pw_back,
    input logic [PW_W_MAX-1:0] pw_stop,
    input logic [PW_W_MAX-1:0] pw_fwd
  );
    case (cmd)
      CMD_FWD:  return pw_fwd;
      CMD_BACK: return pw_back;
      default:  return pw_stop;
    endcase
  endfunction

endpackage

// File: rtl/servo_ramp_ch.sv
// One servo channel: command capture, per-frame target load with slew-limited width, and pulse compare.
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PW_BACK   = DEF_PW_BACK,
  parameter int unsigned PW_STOP   = DEF_PW_STOP,
  parameter int unsigned PW_FWD    = DEF_PW_FWD,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             pwm,
  output logic             at_target
);

  localparam logic [CNT_W-1:0] STOP_W = CNT_W'(PW_STOP);
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(RAMP_STEP);

  cmd_e             pending;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cur_pw;
  logic [CNT_W-1:0] new_target;
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] target_nxt;
  logic [CNT_W-1:0] cur_pw_nxt;

  // Width moves only on the wrap edge; the difference is taken larger-minus-smaller so it never underflows.
  always_comb begin
    new_target = CNT_W'(decode_cmd(pending, PW_W_MAX'(PW_BACK), PW_W_MAX'(PW_STOP),
                                   PW_W_MAX'(PW_FWD)));
    target_nxt = target;
    cur_pw_nxt = cur_pw;
    diff       = '0;
    if (wrap) begin
      target_nxt = new_target;
      if (new_target >= cur_pw) begin
        diff       = new_target - cur_pw;
        cur_pw_nxt = (RAMP_STEP == 0 || diff <= STEP_W) ? new_target : cur_pw + STEP_W;
      end else begin
        diff       = cur_pw - new_target;
        cur_pw_nxt = (RAMP_STEP == 0 || diff <= STEP_W) ? new_target : cur_pw - STEP_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= CMD_STOP;
      target    <= STOP_W;
      cur_pw    <= STOP_W;
      pwm       <= 1'b0;
      at_target <= 1'b1;
    end else begin
      if (cmd_valid) pending <= cmd_e'(cmd);
      target    <= target_nxt;
      cur_pw    <= cur_pw_nxt;
      pwm       <= (cnt < cur_pw);
      at_target <= (cur_pw_nxt == target_nxt);
    end
  end

endmodule

// File: rtl/servo_pwm_array.sv
// Array of independent servo PWM channels sharing one frame counter.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned PW_BACK   = DEF_PW_BACK,
  parameter int unsigned PW_STOP   = DEF_PW_STOP,
  parameter int unsigned PW_FWD    = DEF_PW_FWD,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*N_CH-1:0] cmd,
  input  logic [N_CH-1:0]   cmd_valid,
  output logic [N_CH-1:0]   pwm,
  output logic [N_CH-1:0]   at_target,
  output logic              frame_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  if (64'(FRAME_LEN) > (64'(1) << CNT_W)) begin : g_bad_frame_len
    $error("FRAME_LEN does not fit in CNT_W bits");
  end
  if (PW_FWD >= FRAME_LEN) begin : g_bad_pw_fwd
    $error("PW_FWD must be shorter than FRAME_LEN");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("N_CH must be in 1..16");
  end

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= wrap ? '0 : cnt + CNT_W'(1);
  end

  // Gated by reset so the tick stays low while the counter is held at zero.
  assign frame_tick = (cnt == '0) && !reset;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_ramp_ch #(
      .CNT_W    (CNT_W),
      .PW_BACK  (PW_BACK),
      .PW_STOP  (PW_STOP),
      .PW_FWD   (PW_FWD),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cnt      (cnt),
      .wrap     (wrap),
      .cmd      (cmd[2*i +: 2]),
      .cmd_valid(cmd_valid[i]),
      .pwm      (pwm[i]),
      .at_target(at_target[i])
    );
  end

endmodule
